uart_rx_cfg: RTL and testbench
==============================

// Module: uart_rx_cfg
// PURPOSE
//  Parametrised UART receiver, successor to the fixed 8N1 receiver: configurable data width,
//  parity mode and stop-bit count, with parity/framing/break detection and a line-recovery state.
//  Sits between the FPGA RX pin and the byte-consuming logic (command parser / FIFO) in the i_Clock domain.
//  LSB-first, 1 start bit, mid-bit sampling, single-cycle data-valid strobe.
// PARAMETERS
//  CLKS_PER_BIT  108  i_Clock cycles per bit (Fclk/baud); legal range >= 8
//  DATA_BITS     8    data bits per frame; legal 5..9
//  PARITY        0    0 = none, 1 = odd, 2 = even
//  STOP_BITS     1    stop bits checked; legal 1 or 2
// PORTS
//  i_Clock        in   1          system clock, all logic on rising edge
//  i_Reset        in   1          asynchronous, active-high reset
//  i_Rx_Serial    in   1          asynchronous serial line, idle high
//  o_Rx_DV        out  1          one-cycle strobe: frame complete, o_Rx_Byte and error flags valid
//  o_Rx_Byte      out  DATA_BITS  received data, held until next o_Rx_DV
//  o_Parity_Err   out  1          parity mismatch on the frame of this o_Rx_DV (always 0 if PARITY=0)
//  o_Frame_Err    out  1          at least one stop bit sampled low on this frame
//  o_Break        out  1          frame error with all data bits and parity bit 0 (line held low)
//  o_Busy         out  1          high in every state except IDLE
// BEHAVIOUR
//  - Reset: all outputs 0; both synchroniser flops 1; state IDLE; counters 0. Reset mid-frame aborts
//    the frame with no o_Rx_DV; reception restarts on the next falling edge after release.
//  - i_Rx_Serial passes a 2-flop synchroniser (2-cycle latency); all decisions use the synchronised bit.
//  - Bit counter width $clog2(CLKS_PER_BIT); index counter wide enough for DATA_BITS.
//  - States: IDLE, START, DATA, PARITY, STOP, DONE, WAIT_IDLE.
//  - IDLE: count=0, idx=0. Synced line 0 -> START.
//  - START: count up; at count==(CLKS_PER_BIT-1)/2 sample: 0 -> DATA, count=0; 1 -> IDLE (glitch,
//    no strobe, no error).
//  - DATA: at count==CLKS_PER_BIT-1 sample into o_Rx_Byte-shadow bit idx, count=0; after bit
//    DATA_BITS-1 -> PARITY if PARITY!=0, else STOP. Shadow register, not o_Rx_Byte, is written here.
//  - PARITY: sample at CLKS_PER_BIT-1. Error if XOR(data,parity bit)!=1 (odd) or !=0 (even) -> STOP.
//  - STOP: sample each stop bit at CLKS_PER_BIT-1; any low sample sets frame error. After last
//    stop sample -> DONE.
//  - DONE (1 cycle): o_Rx_DV=1; o_Rx_Byte<=shadow; o_Parity_Err/o_Frame_Err/o_Break driven
//    for this cycle only (0 otherwise). Next: WAIT_IDLE if frame error else IDLE.
//  - WAIT_IDLE: stay until synced line is 1, then IDLE. Prevents a held-low break line from
//    re-triggering as back-to-back zero frames; exactly one o_Rx_DV per break.
//  - Frame latency: o_Rx_DV rises ~2 + (CLKS_PER_BIT-1)/2 + (DATA_BITS+P+STOP_BITS)*CLKS_PER_BIT
//    cycles after the start-bit falling edge (P=1 if parity enabled).
//  - Back-to-back frames: new start bit accepted in the cycle after DONE (last stop sampled at mid-bit,
//    leaving half a bit of margin); no frame lost at nominal baud.
//  - Data error does not suppress o_Rx_DV: consumer decides from the flags.
// TESTING (bench with CLKS_PER_BIT=16 unless stated)
//  1. 8N1, send 0xA5 -> one o_Rx_DV, o_Rx_Byte=0xA5, all error flags 0, o_Busy low after.
//  2. DATA_BITS=7, PARITY=2, send 0x55 with parity 0 then 0x55 with parity 1 -> DV twice,
//     o_Parity_Err 0 then 1; PARITY=1 same stimulus -> 1 then 0.
//  3. STOP_BITS=2, second stop bit driven low, byte 0x3C -> o_Rx_Byte=0x3C, o_Frame_Err=1, o_Break=0.
//  4. Line held low 3 frame times then released -> exactly one DV, o_Rx_Byte=0, o_Frame_Err=1,
//     o_Break=1; next valid 0x81 frame received correctly.
//  5. 4-cycle low glitch in idle -> no o_Rx_DV, o_Busy returns 0 by cycle (CLKS_PER_BIT-1)/2+4.
//  6. Assert i_Reset mid-data of 0xFF, release, send 0x12 -> no DV for aborted frame, then DV with 0x12;
//     plus 16 back-to-back random bytes at DATA_BITS=9 all received in order.

Source files
------------

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 5..9 data bits, none/odd/even parity and 1 or 2 stop bits.
// Reports parity, framing and break errors, then holds off after a frame error until the line idles high.
module uart_rx_cfg #(
  parameter int CLKS_PER_BIT = 108,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset,
  input  logic                 i_Rx_Serial,
  output logic                 o_Rx_DV,
  output logic [DATA_BITS-1:0] o_Rx_Byte,
  output logic                 o_Parity_Err,
  output logic                 o_Frame_Err,
  output logic                 o_Break,
  output logic                 o_Busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_HALF  = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_DONE, S_WAIT_IDLE
  } state_t;

  state_t                 r_state, w_next;
  logic                   r_sync1, r_sync2;
  logic [CW-1:0]          r_cnt;
  logic [IW-1:0]          r_idx;
  logic [DATA_BITS-1:0]   r_shadow;
  logic                   r_par_bit;
  logic                   r_ferr;

  logic w_rx, w_half, w_sample, w_data_last, w_stop_last;
  logic w_ferr_now, w_par_err, w_break;

  assign w_rx        = r_sync2;
  assign w_half      = (r_cnt == CNT_HALF);
  assign w_sample    = (r_cnt == CNT_LAST);
  assign w_data_last = (r_idx == IDX_LAST);
  assign w_stop_last = (r_idx == STOP_LAST);
  assign o_Busy      = (r_state != S_IDLE);

  // Framing error includes the stop bit being sampled right now, so flags are ready with the strobe.
  assign w_ferr_now  = r_ferr | ~w_rx;
  assign w_break     = w_ferr_now & ~(|r_shadow) & ((PARITY == 0) | ~r_par_bit);

  always_comb begin
    w_par_err = 1'b0;
    if (PARITY == 1)      w_par_err = ~(^r_shadow ^ r_par_bit);
    else if (PARITY == 2) w_par_err = ^r_shadow ^ r_par_bit;
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_Rx_Serial;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      if (!w_rx) w_next = S_START;
      S_START:     if (w_half) w_next = w_rx ? S_IDLE : S_DATA;
      S_DATA:      if (w_sample && w_data_last)
                     w_next = (PARITY != 0) ? S_PARITY : S_STOP;
      S_PARITY:    if (w_sample) w_next = S_STOP;
      S_STOP:      if (w_sample && w_stop_last) w_next = S_DONE;
      S_DONE:      w_next = o_Frame_Err ? S_WAIT_IDLE : S_IDLE;
      S_WAIT_IDLE: if (w_rx) w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_cnt        <= '0;
      r_idx        <= '0;
      r_shadow     <= '0;
      r_par_bit    <= 1'b0;
      r_ferr       <= 1'b0;
      o_Rx_DV      <= 1'b0;
      o_Rx_Byte    <= '0;
      o_Parity_Err <= 1'b0;
      o_Frame_Err  <= 1'b0;
      o_Break      <= 1'b0;
    end else begin
      o_Rx_DV      <= 1'b0;
      o_Parity_Err <= 1'b0;
      o_Frame_Err  <= 1'b0;
      o_Break      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cnt     <= '0;
          r_idx     <= '0;
          r_ferr    <= 1'b0;
          r_par_bit <= 1'b0;
        end
        S_START: begin
          if (w_half) r_cnt <= '0;
          else        r_cnt <= r_cnt + 1'b1;
        end
        S_DATA: begin
          if (w_sample) begin
            r_cnt           <= '0;
            r_shadow[r_idx] <= w_rx;
            r_idx           <= w_data_last ? '0 : r_idx + 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_PARITY: begin
          if (w_sample) begin
            r_cnt     <= '0;
            r_par_bit <= w_rx;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (w_sample) begin
            r_cnt  <= '0;
            r_idx  <= r_idx + 1'b1;
            r_ferr <= w_ferr_now;
            // Last stop sample: publish the frame so the strobe lines up with DONE.
            if (w_stop_last) begin
              o_Rx_DV      <= 1'b1;
              o_Rx_Byte    <= r_shadow;
              o_Parity_Err <= w_par_err;
              o_Frame_Err  <= w_ferr_now;
              o_Break      <= w_break;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_cnt <= '0;
          r_idx <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench: five receiver configurations share clock/reset, each with its own serial line.
// Stimulus pushes expected frames; a negedge monitor pops and compares on every o_Rx_DV.
module tb_uart_rx_cfg;

  localparam int CPB = 16;

  logic clk, rst;
  logic [4:0] rx;
  logic [4:0] dv, pe, fe, br, busy;
  logic [7:0] b0, b3;
  logic [6:0] b1, b2;
  logic [8:0] b4;

  typedef struct {
    int         ch;
    logic [8:0] d;
    logic       pe;
    logic       fe;
    logic       br;
  } exp_t;

  exp_t q[$];
  int compared = 0;
  int mismatched = 0;

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx[0]), .o_Rx_DV(dv[0]), .o_Rx_Byte(b0),
    .o_Parity_Err(pe[0]), .o_Frame_Err(fe[0]), .o_Break(br[0]), .o_Busy(busy[0]));
  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) u_7e1 (
    .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx[1]), .o_Rx_DV(dv[1]), .o_Rx_Byte(b1),
    .o_Parity_Err(pe[1]), .o_Frame_Err(fe[1]), .o_Break(br[1]), .o_Busy(busy[1]));
  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(1), .STOP_BITS(1)) u_7o1 (
    .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx[2]), .o_Rx_DV(dv[2]), .o_Rx_Byte(b2),
    .o_Parity_Err(pe[2]), .o_Frame_Err(fe[2]), .o_Break(br[2]), .o_Busy(busy[2]));
  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_8n2 (
    .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx[3]), .o_Rx_DV(dv[3]), .o_Rx_Byte(b3),
    .o_Parity_Err(pe[3]), .o_Frame_Err(fe[3]), .o_Break(br[3]), .o_Busy(busy[3]));
  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(9), .PARITY(0), .STOP_BITS(1)) u_9n1 (
    .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx[4]), .o_Rx_DV(dv[4]), .o_Rx_Byte(b4),
    .o_Parity_Err(pe[4]), .o_Frame_Err(fe[4]), .o_Break(br[4]), .o_Busy(busy[4]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [8:0] byte_of(input int k);
    case (k)
      0: byte_of = {1'b0, b0};
      1: byte_of = {2'b0, b1};
      2: byte_of = {2'b0, b2};
      3: byte_of = {1'b0, b3};
      default: byte_of = b4;
    endcase
  endfunction

  // Monitor: every strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    for (int k = 0; k < 5; k++) begin
      if (dv[k]) begin
        compared++;
        if (q.size() == 0) begin
          mismatched++;
          $display("FAIL unexpected_dv ch%0d: got byte=%h pe=%b fe=%b brk=%b, required no strobe",
                   k, byte_of(k), pe[k], fe[k], br[k]);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (e.ch != k || e.d != byte_of(k) || e.pe != pe[k] || e.fe != fe[k] || e.br != br[k]) begin
            mismatched++;
            $display("FAIL frame ch%0d: got byte=%h pe=%b fe=%b brk=%b, required ch%0d byte=%h pe=%b fe=%b brk=%b",
                     k, byte_of(k), pe[k], fe[k], br[k], e.ch, e.d, e.pe, e.fe, e.br);
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bit_out(input int ch, input logic b);
    rx[ch] = b;
    tick(CPB);
  endtask

  task automatic push(input int ch, input logic [8:0] d, input logic p, input logic f, input logic b);
    exp_t e;
    e.ch = ch; e.d = d; e.pe = p; e.fe = f; e.br = b;
    q.push_back(e);
  endtask

  task automatic send(input int ch, input logic [8:0] d, input int nd, input int haspar,
                      input logic pb, input int nstop, input logic [1:0] stops);
    bit_out(ch, 1'b0);
    for (int i = 0; i < nd; i++) bit_out(ch, d[i]);
    if (haspar != 0) bit_out(ch, pb);
    for (int i = 0; i < nstop; i++) bit_out(ch, stops[i]);
    rx[ch] = 1'b1;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    @(negedge clk);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  initial begin
    logic [8:0] v;
    rst = 1'b1;
    rx  = 5'h1f;
    tick(5);
    for (int k = 0; k < 5; k++)
      check($sformatf("reset_outputs_ch%0d", k),
            {10'd0, dv[k], |byte_of(k), pe[k], fe[k], br[k], busy[k]}, 16'h0);
    rst = 1'b0;
    tick(8);

    // 8N1 0xA5
    push(0, 9'h0A5, 0, 0, 0);
    send(0, 9'h0A5, 8, 0, 1'b0, 1, 2'b11);
    tick(32);
    check("busy_after_a5", {15'd0, busy[0]}, 16'h0);

    // 7 data bits, 0x55 has four ones: even parity wants 0, odd parity wants 1
    push(1, 9'h055, 0, 0, 0);
    send(1, 9'h055, 7, 1, 1'b0, 1, 2'b11);
    push(1, 9'h055, 1, 0, 0);
    send(1, 9'h055, 7, 1, 1'b1, 1, 2'b11);
    tick(32);
    push(2, 9'h055, 1, 0, 0);
    send(2, 9'h055, 7, 1, 1'b0, 1, 2'b11);
    push(2, 9'h055, 0, 0, 0);
    send(2, 9'h055, 7, 1, 1'b1, 1, 2'b11);
    tick(32);

    // Two stop bits, second one low
    push(3, 9'h03C, 0, 1, 0);
    send(3, 9'h03C, 8, 0, 1'b0, 2, 2'b01);
    tick(32);
    check("busy_after_ferr_idle", {15'd0, busy[3]}, 16'h0);

    // Break: line low for three frame times gives exactly one strobe
    push(0, 9'h000, 0, 1, 1);
    rx[0] = 1'b0;
    tick(3 * 10 * CPB);
    check("busy_during_break", {15'd0, busy[0]}, 16'h1);
    rx[0] = 1'b1;
    tick(40);
    check("busy_after_break", {15'd0, busy[0]}, 16'h0);
    push(0, 9'h081, 0, 0, 0);
    send(0, 9'h081, 8, 0, 1'b0, 1, 2'b11);
    tick(32);

    // Four-cycle glitch: START for a while, back to IDLE by cycle 11
    rx[0] = 1'b0;
    tick(4);
    rx[0] = 1'b1;
    tick(1);
    check("busy_in_glitch", {15'd0, busy[0]}, 16'h1);
    tick(6);
    check("busy_after_glitch", {15'd0, busy[0]}, 16'h0);
    tick(32);

    // Reset in the middle of 0xFF data bits aborts the frame
    bit_out(0, 1'b0);
    bit_out(0, 1'b1);
    bit_out(0, 1'b1);
    check("busy_before_abort", {15'd0, busy[0]}, 16'h1);
    rst = 1'b1;
    tick(3);
    check("busy_in_reset", {15'd0, busy[0]}, 16'h0);
    rst = 1'b0;
    tick(32);
    push(0, 9'h012, 0, 0, 0);
    send(0, 9'h012, 8, 0, 1'b0, 1, 2'b11);
    tick(32);

    // Back-to-back 9-bit frames, no idle gap between stop and next start
    for (int i = 0; i < 16; i++) begin
      v = 9'($urandom_range(0, 511));
      push(4, v, 0, 0, 0);
      send(4, v, 9, 0, 1'b0, 1, 2'b11);
    end
    tick(64);

    check("outstanding_frames", 16'(q.size()), 16'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
